mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, operand width.
REQ-002 Parameter NREQ, default 4, requester count (fixed 4 in this revision; index width 2).
REQ-003 Clock  input  1  single clock, all logic on posedge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 iReq  input  NREQ  per-requester request; held high until granted.
REQ-006 iOperands  input  NREQ*4*WIDTH  per-requester {A,B,C,D}; requester r occupies bits [r*4*WIDTH +: 4*WIDTH], A in the most significant slice.
REQ-007 oGrant  output  NREQ  one-hot, one-cycle pulse; operands captured that cycle.
REQ-008 oMul_A, oMul_B, oMul_C, oMul_D  output  WIDTH  operands driven to the shared multiplier.
REQ-009 oMul_Valid  output  1  multiplier iValid_Data.
REQ-010 oMul_Ack  output  1  multiplier iAcknoledged.
REQ-011 iMul_Done, iMul_Idle  input  1  multiplier oDone and oIdle.
REQ-012 iMul_Result  input  4*WIDTH  multiplier oResult.
REQ-013 oResult  output  4*WIDTH  captured product.
REQ-014 oResult_Valid  output  1  oResult and oResult_Id valid.
REQ-015 oResult_Id  output  2  requester index owning oResult.
REQ-016 iResult_Ack  input  1  consumer accepts the result.
REQ-017 oBusy  output  1  high in every state except ARB.

Function
REQ-018 FSM states: ARB, ISSUE, WAIT_DONE, ACK, RELEASE, DELIVER.
REQ-019 ARB: if any iReq bit is high and iMul_Idle=1, grant the first requester at or after (last_served+1) mod NREQ, searching in round-robin order. On that edge: pulse oGrant, latch its operands into oMul_A..D, latch its index, then go to ISSUE.
REQ-020 ARB with no request, or with iMul_Idle=0: stay in ARB; oGrant stays 0.
REQ-021 ISSUE: hold oMul_Valid=1 until iMul_Done=1 is sampled, then go to ACK; oMul_A..D stay stable.
REQ-022 oMul_Valid is low in every state except ISSUE.
REQ-023 WAIT_DONE: a reserved encoding; ISSUE moves directly to ACK, and a stray WAIT_DONE returns to ARB.
REQ-024 ACK: on entry, capture iMul_Result into oResult and drive oMul_Ack=1. Stay in ACK until iMul_Done=0, then go to RELEASE.
REQ-025 RELEASE: drop oMul_Ack to 0, wait for iMul_Idle=1, then go to DELIVER.
REQ-026 DELIVER: hold oResult_Valid=1 with oResult_Id equal to the granted index until iResult_Ack=1. On that edge, update last_served to the granted index and go to ARB.
REQ-027 iResult_Ack sampled outside DELIVER is ignored.
REQ-028 Requests arriving in any state other than ARB are not lost; they are served in a later ARB in round-robin order.
REQ-029 A requester that drops iReq before being granted is not served; no error is flagged.
REQ-030 Latency: grant to oMul_Valid is 1 cycle. iResult_Ack to the next oGrant is 1 cycle when iMul_Idle=1.
REQ-031 oResult is the full 4*WIDTH multiplier output, unmodified; oResult and oResult_Id keep their values after delivery until the next capture.
REQ-032 When all requesters request continuously, each is granted exactly once per NREQ grants.

Reset
REQ-033 When Reset is high at a clock edge:
- state becomes ARB and last_served becomes NREQ-1, so requester 0 has first priority;
- oGrant, oMul_Valid, oMul_Ack, oResult_Valid, oBusy become 0;
- oMul_A..D, oResult, oResult_Id become 0.
REQ-034 Reset asserted mid-transaction abandons that transaction; no result is delivered for it. The multiplier is reset by the same Reset line.

Structure
REQ-035 A shared package holds the FSM state encoding and the default WIDTH/NREQ constants.
REQ-036 One sub-module, rr_picker, is combinational: inputs are request vector and last_served; outputs are one-hot grant and index.

Verification
REQ-037 Single request: Reset, then iReq=0001 with operands {1,2,3,4} -> oGrant=0001 one cycle, oMul_Valid asserted, then oResult=24, oResult_Id=0, oResult_Valid held until iResult_Ack.
REQ-038 All-request fairness: iReq=1111 held through 8 transactions -> oResult_Id sequence is 0,1,2,3,0,1,2,3.
REQ-039 Back-pressure: iResult_Ack held 0 for 20 cycles in DELIVER -> oResult_Valid and oResult stable, no new oGrant; a new request made meanwhile is granted 1 cycle after iResult_Ack.
REQ-040 Idle gating: iMul_Idle forced 0 while iReq=0100 -> no grant; once iMul_Idle=1, grant 0100 on the next edge.
REQ-041 Reset mid-operation: Reset in ACK state -> next cycle all outputs 0, state ARB; iReq=0010 still high is then granted first.
REQ-042 Product width: operands {16'hFFFF x4} -> oResult equals 64'hFFFC_0005_FFFC_0001 (the full 64-bit product of the four operands).

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// Shared constants and FSM state encoding for the multiplier arbiter.
package mult_arbiter_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREQ  = 4;
  localparam int IDX_W     = 2;

  // WAIT_DONE is reserved: ISSUE goes straight to ACK, and a stray
  // WAIT_DONE falls back to ARB.
  typedef enum logic [2:0] {
    ST_ARB       = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_ACK       = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_DELIVER   = 3'd5
  } state_e;

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester, multiplier and result-consumer signals of the arbiter.
interface mult_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]         iReq;
  logic [NREQ*4*WIDTH-1:0] iOperands;
  logic [NREQ-1:0]         oGrant;
  logic [WIDTH-1:0]        oMul_A;
  logic [WIDTH-1:0]        oMul_B;
  logic [WIDTH-1:0]        oMul_C;
  logic [WIDTH-1:0]        oMul_D;
  logic                    oMul_Valid;
  logic                    oMul_Ack;
  logic                    iMul_Done;
  logic                    iMul_Idle;
  logic [4*WIDTH-1:0]      iMul_Result;
  logic [4*WIDTH-1:0]      oResult;
  logic                    oResult_Valid;
  logic [1:0]              oResult_Id;
  logic                    iResult_Ack;
  logic                    oBusy;

  // Arbiter side.
  modport slave (
    input  iReq, iOperands, iMul_Done, iMul_Idle, iMul_Result, iResult_Ack,
    output oGrant, oMul_A, oMul_B, oMul_C, oMul_D, oMul_Valid, oMul_Ack,
           oResult, oResult_Valid, oResult_Id, oBusy
  );

  // Environment side (requesters, multiplier, consumer).
  modport master (
    output iReq, iOperands, iMul_Done, iMul_Idle, iMul_Result, iResult_Ack,
    input  oGrant, oMul_A, oMul_B, oMul_C, oMul_D, oMul_Valid, oMul_Ack,
           oResult, oResult_Valid, oResult_Id, oBusy
  );
endinterface

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after last+1.
module rr_picker
  import mult_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand_s;

  // Scan last+1 .. last+NREQ (wrapping) and keep the first active request.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand_s  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = last_i + IDX_W'(i);
      if (!valid_o && req_i[cand_s]) begin
        valid_o         = 1'b1;
        grant_o[cand_s] = 1'b1;
        idx_o           = cand_s;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one four-operand multiplier among requesters.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input logic           Clock,
  input logic           Reset,
  mult_arbiter_if.slave bus
);

  state_e             state_q;
  logic [IDX_W-1:0]   last_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NREQ-1:0]    grant_q;
  logic [WIDTH-1:0]   a_q, b_q, c_q, d_q;
  logic               valid_q, ack_q, rvalid_q, busy_q;
  logic [4*WIDTH-1:0] result_q;
  logic [IDX_W-1:0]   rid_q;

  logic [NREQ-1:0]    pick_grant_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_valid_s;
  logic [4*WIDTH-1:0] sel_ops_s;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i   (bus.iReq),
    .last_i  (last_q),
    .grant_o (pick_grant_s),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  assign sel_ops_s = bus.iOperands[int'(pick_idx_s)*4*WIDTH +: 4*WIDTH];

  // Transaction FSM; every output is a register updated alongside the state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_ARB;
      last_q   <= IDX_W'(NREQ-1);
      idx_q    <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      rid_q    <= '0;
    end else begin
      grant_q <= '0;
      case (state_q)
        ST_ARB: begin
          if (pick_valid_s && bus.iMul_Idle) begin
            grant_q <= pick_grant_s;
            a_q     <= sel_ops_s[4*WIDTH-1:3*WIDTH];
            b_q     <= sel_ops_s[3*WIDTH-1:2*WIDTH];
            c_q     <= sel_ops_s[2*WIDTH-1:WIDTH];
            d_q     <= sel_ops_s[WIDTH-1:0];
            idx_q   <= pick_idx_s;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Result is captured on the same edge the done is seen.
          if (bus.iMul_Done) begin
            valid_q  <= 1'b0;
            ack_q    <= 1'b1;
            result_q <= bus.iMul_Result;
            rid_q    <= idx_q;
            state_q  <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!bus.iMul_Done) begin
            ack_q   <= 1'b0;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (bus.iMul_Idle) begin
            rvalid_q <= 1'b1;
            state_q  <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          if (bus.iResult_Ack) begin
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            last_q   <= idx_q;
            state_q  <= ST_ARB;
          end
        end
        default: begin
          // Covers the reserved WAIT_DONE encoding and any illegal value.
          valid_q  <= 1'b0;
          ack_q    <= 1'b0;
          rvalid_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_ARB;
        end
      endcase
    end
  end

  assign bus.oGrant        = grant_q;
  assign bus.oMul_A        = a_q;
  assign bus.oMul_B        = b_q;
  assign bus.oMul_C        = c_q;
  assign bus.oMul_D        = d_q;
  assign bus.oMul_Valid    = valid_q;
  assign bus.oMul_Ack      = ack_q;
  assign bus.oResult       = result_q;
  assign bus.oResult_Valid = rvalid_q;
  assign bus.oResult_Id    = rid_q;
  assign bus.oBusy         = busy_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomised bench for mult_arbiter with a behavioural multiplier and
// a transaction-level reference model of grants and results.
module tb_mult_arbiter;

  logic Clock;
  logic Reset;

  mult_arbiter_if bus ();

  mult_arbiter dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  // Requesters and consumer.
  logic [3:0]  req_drv;
  logic [63:0] opv [4];
  logic        keep_req, ack_drv, ack_sent, spur_en;
  int          ack_delay, wait_cnt;

  // Multiplier model.
  logic        mul_idle_m, hold_idle_low;
  int          ph, cnt;

  // Reference model state.
  int          last_ref, cur_id, last_rid;
  logic        in_flight, ready_nx, valid_chk;
  logic [63:0] exp_prod, last_res;
  int          dq [$];

  assign bus.iMul_Idle = mul_idle_m && !hold_idle_low;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] prod4(input logic [63:0] ops);
    logic [63:0] a, b, c, d;
    a = 64'(ops[63:48]);
    b = 64'(ops[47:32]);
    c = 64'(ops[31:16]);
    d = 64'(ops[15:0]);
    return a * b * c * d;
  endfunction

  // Round-robin rule: first requester at (last+1), (last+2), ... mod 4.
  function automatic logic [3:0] ref_pick(input logic [3:0] req, input int last);
    logic [3:0] g;
    g = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      if (g == 4'b0000 && req[(last + k) % 4]) g[(last + k) % 4] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [255:0] pack_ops();
    logic [255:0] v;
    for (int r = 0; r < 4; r++) v[r*64 +: 64] = opv[r];
    return v;
  endfunction

  // One clock: drive inputs, wait for edge, check outputs, advance models.
  task automatic step();
    logic [3:0] req_prev, exp_g;
    logic       idle_prev, ready_prev, rst_prev;
    req_prev   = req_drv;
    idle_prev  = mul_idle_m && !hold_idle_low;
    ready_prev = ready_nx;
    rst_prev   = Reset;
    bus.iReq        = req_drv;
    bus.iOperands   = pack_ops();
    bus.iResult_Ack = ack_drv;
    @(posedge Clock);
    #1;
    ack_sent = 1'b0;
    if (rst_prev) begin
      check_eq("rst_grant",  64'(bus.oGrant), 64'd0);
      check_eq("rst_mvalid", 64'(bus.oMul_Valid), 64'd0);
      check_eq("rst_mack",   64'(bus.oMul_Ack), 64'd0);
      check_eq("rst_rvalid", 64'(bus.oResult_Valid), 64'd0);
      check_eq("rst_busy",   64'(bus.oBusy), 64'd0);
      check_eq("rst_ops",    {bus.oMul_A, bus.oMul_B, bus.oMul_C, bus.oMul_D}, 64'd0);
      check_eq("rst_result", bus.oResult, 64'd0);
      check_eq("rst_rid",    64'(bus.oResult_Id), 64'd0);
      bus.iMul_Done = 1'b0; bus.iMul_Result = 64'd0; mul_idle_m = 1'b1; ph = 0;
      last_ref = 3; in_flight = 1'b0; ack_drv = 1'b0; wait_cnt = 0;
      valid_chk = 1'b0; ready_nx = 1'b1;
    end else begin
      exp_g = (ready_prev && idle_prev) ? ref_pick(req_prev, last_ref) : 4'b0000;
      check_eq("grant", 64'(bus.oGrant), 64'(exp_g));
      if (valid_chk) check_eq("mul_valid_after_grant", 64'(bus.oMul_Valid), 64'd1);
      valid_chk = 1'b0;
      if (exp_g != 4'b0000) begin
        for (int r = 0; r < 4; r++) if (exp_g[r]) cur_id = r;
        check_eq("mul_operands", {bus.oMul_A, bus.oMul_B, bus.oMul_C, bus.oMul_D}, opv[cur_id]);
        exp_prod  = prod4(opv[cur_id]);
        in_flight = 1'b1;
        valid_chk = 1'b1;
        if (!keep_req) req_drv[cur_id] = 1'b0;
      end
      check_eq("busy", 64'(bus.oBusy), 64'(in_flight));
      // Behavioural multiplier: idle drops on valid, done after a delay,
      // done drops after the ack, idle returns after another delay.
      case (ph)
        0: if (bus.oMul_Valid) begin mul_idle_m = 1'b0; cnt = $urandom_range(0, 3); ph = 1; end
        1: if (cnt == 0) begin
             bus.iMul_Done = 1'b1;
             bus.iMul_Result = prod4({bus.oMul_A, bus.oMul_B, bus.oMul_C, bus.oMul_D});
             ph = 2;
           end else cnt--;
        2: if (bus.oMul_Ack) begin
             bus.iMul_Done = 1'b0; bus.iMul_Result = {$urandom, $urandom};
             cnt = $urandom_range(0, 3); ph = 3;
           end
        default: if (cnt == 0) begin mul_idle_m = 1'b1; ph = 0; end else cnt--;
      endcase
      if (bus.oResult_Valid) begin
        check_eq("rvalid_owner", 64'(in_flight), 64'd1);
        check_eq("result_id", 64'(bus.oResult_Id), 64'(cur_id));
        check_eq("result", bus.oResult, exp_prod);
        if (wait_cnt >= ack_delay) begin
          ack_drv = 1'b1; ack_sent = 1'b1; in_flight = 1'b0; last_ref = cur_id;
          dq.push_back(cur_id); last_res = bus.oResult; last_rid = int'(bus.oResult_Id);
          wait_cnt = 0;
        end else begin
          ack_drv = 1'b0; wait_cnt++;
        end
      end else begin
        ack_drv = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      ready_nx = !in_flight && !ack_sent;
    end
  endtask

  task automatic wait_quiet(input int max_cyc);
    int n;
    n = 0;
    while ((in_flight || req_drv != 4'b0000 || !ready_nx) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) check_eq("quiet_timeout", 64'(in_flight), 64'd0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    int n;
    Reset = 1'b1; req_drv = 4'b0000; keep_req = 1'b0; ack_drv = 1'b0; spur_en = 1'b0;
    ack_delay = 1; wait_cnt = 0; mul_idle_m = 1'b1; hold_idle_low = 1'b0; ph = 0; cnt = 0;
    last_ref = 3; cur_id = 0; last_rid = -1; in_flight = 1'b0; ready_nx = 1'b0;
    valid_chk = 1'b0; exp_prod = 64'd0; last_res = 64'd0; ack_sent = 1'b0;
    bus.iMul_Done = 1'b0; bus.iMul_Result = 64'd0;
    for (int r = 0; r < 4; r++) opv[r] = 64'd0;
    do_reset();

    // Single request {1,2,3,4} from requester 0.
    opv[0] = {16'd1, 16'd2, 16'd3, 16'd4};
    req_drv = 4'b0001; ack_delay = 2;
    wait_quiet(100);
    check_eq("single_rid", 64'(last_rid), 64'd0);
    check_eq("single_result", last_res, 64'd24);

    // Fairness with all four requesting continuously.
    do_reset();
    for (int r = 0; r < 4; r++) opv[r] = {$urandom, $urandom};
    dq.delete(); keep_req = 1'b1; req_drv = 4'b1111; ack_delay = 0;
    n = 0;
    while (dq.size() < 8 && n < 400) begin step(); n++; end
    keep_req = 1'b0; req_drv = 4'b0000;
    wait_quiet(100);
    check_eq("fair_count", 64'(dq.size() >= 8), 64'd1);
    for (int i = 0; i < 8 && i < dq.size(); i++) check_eq("fair_order", 64'(dq[i]), 64'(i % 4));

    // Back-pressure: 20 cycles without ack, new request waiting meanwhile.
    opv[0] = {$urandom, $urandom}; req_drv = 4'b0001; ack_delay = 20;
    n = 0;
    while (!bus.oResult_Valid && n < 100) begin step(); n++; end
    check_eq("bp_reached_deliver", 64'(bus.oResult_Valid), 64'd1);
    opv[3] = {$urandom, $urandom}; req_drv[3] = 1'b1;
    n = 0;
    while (!ack_sent && n < 40) begin step(); n++; end
    check_eq("bp_acked", 64'(ack_sent), 64'd1);
    ack_delay = 1;
    step();
    step();
    check_eq("bp_regrant", 64'(bus.oGrant), 64'b1000);
    wait_quiet(100);

    // Idle gating.
    hold_idle_low = 1'b1; opv[2] = {$urandom, $urandom}; req_drv = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("idle_gate_nogrant", 64'(bus.oGrant), 64'd0);
    end
    hold_idle_low = 1'b0;
    step();
    check_eq("idle_gate_grant", 64'(bus.oGrant), 64'b0100);
    wait_quiet(100);

    // Reset in ACK abandons the transaction; waiting requester 1 goes first.
    opv[0] = {$urandom, $urandom}; req_drv = 4'b0001;
    n = 0;
    while (!bus.oMul_Ack && n < 50) begin step(); n++; end
    check_eq("reached_ack", 64'(bus.oMul_Ack), 64'd1);
    opv[1] = {$urandom, $urandom}; req_drv[1] = 1'b1;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
    check_eq("rst_first_grant", 64'(bus.oGrant), 64'b0010);
    wait_quiet(100);

    // Full-width product.
    opv[2] = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; req_drv = 4'b0100;
    wait_quiet(100);
    check_eq("wide_product", last_res, 64'hFFFC_0005_FFFC_0001);
    check_eq("wide_rid", 64'(last_rid), 64'd2);

    // Random traffic: arrivals, withdrawals, idle glitches, stray acks.
    spur_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!req_drv[r] && $urandom_range(0, 7) == 0) begin
          opv[r] = {$urandom, $urandom}; req_drv[r] = 1'b1;
        end else if (req_drv[r] && $urandom_range(0, 63) == 0) begin
          req_drv[r] = 1'b0;
        end
      end
      ack_delay = $urandom_range(0, 3);
      hold_idle_low = ($urandom_range(0, 15) == 0);
      step();
    end
    hold_idle_low = 1'b0; req_drv = 4'b0000; spur_en = 1'b0;
    wait_quiet(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
